// File: rtl/bridge_ctrl.sv
// CPU peripheral-port bridge: decodes NDEV 16-byte device windows plus an
// interrupt controller window at index NDEV, and drives the registered HWInt vector.

module bridge_irq_line #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_i,
    input  logic clr_i,
    output logic status_o
);
    logic prev_q, status_q, status_d;

    // A rising edge in the same cycle as a W1C clear keeps the bit set.
    always_comb begin
        status_d = irq_i;
        if (EDGE) status_d = (status_q & ~clr_i) | (irq_i & ~prev_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q   <= 1'b0;
            status_q <= 1'b0;
        end else begin
            prev_q   <= irq_i;
            status_q <= status_d;
        end
    end

    assign status_o = status_q;
endmodule

module bridge_ctrl #(
    parameter int          NDEV     = 3,
    parameter logic [27:0] BASE_HI  = 28'h000_07F0,
    parameter int          IRQ_W    = 6,
    parameter logic [5:0]  IRQ_EDGE = 6'b000000,
    parameter int          RD_WAIT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          pr_addr,
    input  logic [31:0]          pr_wd,
    input  logic                 pr_we,
    input  logic                 pr_re,
    output logic [31:0]          pr_rd,
    output logic                 pr_ready,
    output logic                 pr_err,
    output logic [NDEV-1:0]      dev_we,
    output logic [31:0]          dev_wd,
    output logic [1:0]           dev_addr,
    input  logic [32*NDEV-1:0]   dev_rd,
    input  logic [IRQ_W-1:0]     irq_in,
    output logic [5:0]           hw_int
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic       we;
        logic       miss;
        logic [3:0] idx;
    } req_t;

    state_t           state_q, state_d;
    req_t             req_q, req_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      rd_q, rd_d, wd_q, wd_d;
    logic [1:0]       waddr_q, waddr_d;
    logic [IRQ_W-1:0] status, mask_q, mask_d, clr;
    logic [5:0]       hw_q;
    logic [27:0]      off;
    logic             ctl_sel;
    logic [31:0]      rd_sel;
    logic             unused_ok;

    assign off       = pr_addr[31:4] - BASE_HI;
    assign ctl_sel   = (req_q.idx == 4'(NDEV)) & ~req_q.miss;
    assign unused_ok = &{1'b0, pr_addr[1:0]};

    for (genvar j = 0; j < IRQ_W; j++) begin : g_irq
        bridge_irq_line #(.EDGE(IRQ_EDGE[j])) u_line (
            .clk      (clk),
            .rst_n    (rst_n),
            .irq_i    (irq_in[j]),
            .clr_i    (clr[j]),
            .status_o (status[j])
        );
    end

    // Read mux: misses return all ones, controller offsets 0x8/0xC read zero.
    always_comb begin
        rd_sel = 32'hFFFF_FFFF;
        if (ctl_sel) begin
            case (waddr_q)
                2'd0:    rd_sel = 32'(status);
                2'd1:    rd_sel = 32'(mask_q);
                default: rd_sel = 32'h0;
            endcase
        end else if (!req_q.miss) begin
            for (int i = 0; i < NDEV; i++)
                if (req_q.idx == 4'(i)) rd_sel = dev_rd[32*i +: 32];
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        wd_d     = wd_q;
        waddr_d  = waddr_q;
        mask_d   = mask_q;
        clr      = '0;
        dev_we   = '0;
        pr_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (pr_we || pr_re) begin
                    req_d.we   = pr_we;
                    req_d.miss = (off > 28'(NDEV));
                    req_d.idx  = off[3:0];
                    wd_d       = pr_wd;
                    waddr_d    = pr_addr[3:2];
                    cnt_d      = 4'd0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (req_q.we) begin
                    if (ctl_sel) begin
                        if (waddr_q == 2'd0) clr = wd_q[IRQ_W-1:0];
                        else if (waddr_q == 2'd1) mask_d = wd_q[IRQ_W-1:0];
                    end else if (!req_q.miss) begin
                        for (int i = 0; i < NDEV; i++)
                            dev_we[i] = (req_q.idx == 4'(i));
                    end
                    state_d = DONE;
                end else if (cnt_q == 4'(RD_WAIT - 1)) begin
                    rd_d    = rd_sel;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                pr_ready = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= 4'd0;
            rd_q    <= 32'h0;
            wd_q    <= 32'h0;
            waddr_q <= 2'd0;
            mask_q  <= '1;
            hw_q    <= 6'h0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wd_q    <= wd_d;
            waddr_q <= waddr_d;
            mask_q  <= mask_d;
            hw_q    <= 6'(status & mask_q);
        end
    end

    assign pr_rd    = rd_q;
    assign pr_err   = pr_ready & req_q.miss;
    assign dev_wd   = wd_q;
    assign dev_addr = waddr_q;
    assign hw_int   = hw_q;
endmodule

// File: tb/tb_bridge_ctrl.sv
// Randomized bench for bridge_ctrl: transaction-schedule reference model checked
// every cycle, plus directed literal expectations for the key scenarios.

module tb_bridge_ctrl;
    localparam int         RW   = 3;
    localparam logic [5:0] EDGE = 6'b000010;

    logic        clk, rst_n;
    logic [31:0] pr_addr, pr_wd, pr_rd, dev_wd;
    logic        pr_we, pr_re, pr_ready, pr_err;
    logic [2:0]  dev_we;
    logic [1:0]  dev_addr;
    logic [95:0] dev_rd, dev_rd_dir, dev_rd_rnd;
    logic [5:0]  irq_in, irq_dir, irq_rnd, hw_int;
    bit          irq_rand, dev_rand, chk_en;

    int n_chk = 0, n_pass = 0;

    logic [2:0]  s_we   [0:63];
    logic [1:0]  s_addr [0:63];
    logic [31:0] s_wd   [0:63];

    assign dev_rd = dev_rand ? dev_rd_rnd : dev_rd_dir;
    assign irq_in = irq_rand ? irq_rnd : irq_dir;

    bridge_ctrl #(
        .NDEV(3), .BASE_HI(28'h000_07F0), .IRQ_W(6), .IRQ_EDGE(EDGE), .RD_WAIT(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pr_addr(pr_addr), .pr_wd(pr_wd), .pr_we(pr_we),
        .pr_re(pr_re), .pr_rd(pr_rd), .pr_ready(pr_ready), .pr_err(pr_err),
        .dev_we(dev_we), .dev_wd(dev_wd), .dev_addr(dev_addr), .dev_rd(dev_rd),
        .irq_in(irq_in), .hw_int(hw_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic bit is_dev(input logic [31:0] a);
        return (a[31:4] >= 28'h7F0) && (a[31:4] <= 28'h7F2);
    endfunction

    function automatic bit is_ctl(input logic [31:0] a);
        return a[31:4] == 28'h7F3;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [5:0] st,
                                           input logic [5:0] mk, input logic [95:0] d);
        if (is_dev(a)) return d[32*a[5:4] +: 32];
        if (is_ctl(a)) begin
            if (a[3:2] == 2'd0) return {26'h0, st};
            if (a[3:2] == 2'd1) return {26'h0, mk};
            return 32'h0;
        end
        return 32'hFFFF_FFFF;
    endfunction

    // Reference model: a transaction starting in cycle t0 writes at t0+1,
    // samples read data at t0+RW, and completes at t0+latency-1.
    bit          busy, m_we;
    int          t0, cyc;
    logic [31:0] m_addr, m_wd, m_rdh;
    logic [5:0]  m_st, m_mask, m_prev, m_hw;

    initial begin
        busy = 0; m_we = 0; t0 = 0; cyc = 0; m_addr = 0; m_wd = 0; m_rdh = 0;
        m_st = 0; m_mask = 6'h3F; m_prev = 0; m_hw = 0;
        forever begin
            int k, lat;
            logic [5:0] clr, nmask;
            @(posedge clk);
            if (!rst_n) begin
                busy = 0; m_addr = 0; m_wd = 0; m_rdh = 0;
                m_st = 0; m_mask = 6'h3F; m_prev = 0; m_hw = 0;
            end else begin
                k = cyc - t0;
                lat = m_we ? 3 : 2 + RW;
                clr = 0;
                nmask = m_mask;
                if (busy && m_we && k == 1 && is_ctl(m_addr)) begin
                    if (m_addr[3:2] == 2'd0) clr = m_wd[5:0];
                    else if (m_addr[3:2] == 2'd1) nmask = m_wd[5:0];
                end
                if (busy && !m_we && k == RW) m_rdh = m_read(m_addr, m_st, m_mask, dev_rd);
                m_hw = m_st & m_mask;
                m_st = (EDGE & ((m_st & ~clr) | (irq_in & ~m_prev))) | (~EDGE & irq_in);
                m_prev = irq_in;
                m_mask = nmask;
                if (busy) begin
                    if (k == lat - 1) busy = 0;
                end else if (pr_we || pr_re) begin
                    busy = 1; t0 = cyc; m_we = pr_we; m_addr = pr_addr; m_wd = pr_wd;
                end
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            int k, lat;
            bit e_ready;
            logic [2:0] e_we;
            @(negedge clk);
            if (chk_en) begin
                k = cyc - t0;
                lat = m_we ? 3 : 2 + RW;
                e_ready = busy && (k == lat - 1);
                e_we = (busy && m_we && k == 1 && is_dev(m_addr)) ? (3'b001 << m_addr[5:4]) : 3'b000;
                chk("ready",  32'(pr_ready), 32'(e_ready));
                chk("err",    32'(pr_err),   32'(e_ready && !is_dev(m_addr) && !is_ctl(m_addr)));
                chk("dev_we", 32'(dev_we),   32'(e_we));
                chk("dev_wd", dev_wd,        m_wd);
                chk("dev_addr", 32'(dev_addr), 32'(m_addr[3:2]));
                chk("pr_rd",  pr_rd,         m_rdh);
                chk("hw_int", 32'(hw_int),   32'(m_hw));
            end
        end
    end

    initial begin
        dev_rd_rnd = 0;
        irq_rnd = 0;
        forever begin
            @(posedge clk);
            #1;
            dev_rd_rnd = {$urandom, $urandom, $urandom};
            for (int j = 0; j < 6; j++)
                if ($urandom_range(0, 7) == 0) irq_rnd[j] = ~irq_rnd[j];
        end
    end

    task automatic txn(input bit we, input bit re, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat);
        int n;
        bit done;
        @(posedge clk);
        #1;
        pr_we = we; pr_re = re; pr_addr = addr; pr_wd = wd;
        n = 0; done = 0; rd = 0; err = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            s_we[n] = dev_we; s_addr[n] = dev_addr; s_wd[n] = dev_wd;
            n++;
            if (pr_ready) begin
                done = 1; rd = pr_rd; err = pr_err;
            end
        end
        lat = n;
        chk("txn_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        pr_we = 0; pr_re = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic err;
        int lat, nrdy;
        pr_we = 0; pr_re = 0; pr_addr = 0; pr_wd = 0; rst_n = 0;
        irq_rand = 0; dev_rand = 1; irq_dir = 0; dev_rd_dir = 0; chk_en = 0;
        @(posedge clk);
        #1 chk_en = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_ready", 32'(pr_ready), 32'd0);
        chk("rst_rd", pr_rd, 32'd0);
        chk("rst_hw", 32'(hw_int), 32'd0);
        chk("rst_dev_we", 32'(dev_we), 32'd0);
        txn(0, 1, 32'h7F34, 0, rd, err, lat);
        chk("rst_mask", rd, 32'h3F);

        txn(1, 0, 32'h7F24, 32'hDEAD_BEEF, rd, err, lat);
        chk("wr_dev_we", 32'(s_we[1]), 32'h4);
        chk("wr_dev_addr", 32'(s_addr[1]), 32'h1);
        chk("wr_dev_wd", s_wd[1], 32'hDEAD_BEEF);
        chk("wr_lat", 32'(lat), 32'd3);
        chk("wr_err", 32'(err), 32'd0);

        dev_rd_dir = {32'hCAFE_0002, 32'h1234_5678, 32'hCAFE_0000};
        dev_rand = 0;
        txn(0, 1, 32'h7F10, 0, rd, err, lat);
        chk("rd_lat", 32'(lat), 32'd5);
        chk("rd_data", rd, 32'h1234_5678);
        chk("rd_err", 32'(err), 32'd0);

        txn(0, 1, 32'h7F80, 0, rd, err, lat);
        chk("miss_rd_err", 32'(err), 32'd1);
        chk("miss_rd_data", rd, 32'hFFFF_FFFF);
        chk("miss_rd_lat", 32'(lat), 32'd5);
        txn(1, 0, 32'h7F80, 32'h5555_AAAA, rd, err, lat);
        chk("miss_wr_err", 32'(err), 32'd1);
        chk("miss_wr_we", 32'(s_we[1]), 32'd0);
        chk("miss_wr_lat", 32'(lat), 32'd3);

        @(posedge clk);
        #1 irq_dir[1] = 1'b1;
        @(posedge clk);
        #1 irq_dir[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("edge_hw", 32'(hw_int), 32'h2);
        txn(0, 1, 32'h7F30, 0, rd, err, lat);
        chk("edge_status", rd, 32'h2);
        txn(1, 0, 32'h7F30, 32'h2, rd, err, lat);
        @(negedge clk);
        chk("w1c_hw", 32'(hw_int), 32'h0);
        @(posedge clk);
        #1 irq_dir[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("level_hi_hw", 32'(hw_int), 32'h1);
        @(posedge clk);
        #1 irq_dir[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("level_lo_hw", 32'(hw_int), 32'h0);

        @(posedge clk);
        #1 irq_dir[0] = 1'b1;
        txn(1, 0, 32'h7F34, 32'h0, rd, err, lat);
        @(negedge clk);
        chk("mask0_hw", 32'(hw_int), 32'h0);
        txn(0, 1, 32'h7F30, 0, rd, err, lat);
        chk("mask0_status", rd, 32'h1);
        txn(0, 1, 32'h7F34, 0, rd, err, lat);
        chk("mask0_read", rd, 32'h0);
        txn(0, 1, 32'h7F38, 0, rd, err, lat);
        chk("ctl_pad_read", rd, 32'h0);
        chk("ctl_pad_err", 32'(err), 32'd0);
        irq_dir = 0;

        @(posedge clk);
        #1 pr_re = 1; pr_addr = 32'h7F10;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_n = 0; pr_re = 0;
        @(posedge clk);
        #1 rst_n = 1;
        nrdy = 0;
        repeat (6) begin
            @(negedge clk);
            if (pr_ready) nrdy++;
        end
        chk("abort_no_ready", 32'(nrdy), 32'd0);
        txn(0, 1, 32'h7F10, 0, rd, err, lat);
        chk("after_abort_rd", rd, 32'h1234_5678);
        chk("after_abort_lat", 32'(lat), 32'd5);

        irq_rand = 1;
        dev_rand = 1;
        for (int i = 0; i < 200; i++) begin
            int sel, op;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            if (sel < 6) a = 32'h7F00 + 32'($urandom_range(0, 2) * 16) + 32'($urandom_range(0, 15));
            else if (sel < 8) a = 32'h7F30 + 32'($urandom_range(0, 15));
            else begin
                case ($urandom_range(0, 2))
                    0: a = 32'h7F40 + 32'($urandom_range(0, 15));
                    1: a = 32'h7EF0 + 32'($urandom_range(0, 15));
                    default: a = $urandom;
                endcase
            end
            op = $urandom_range(0, 2);
            txn(op != 1, op != 0, a, $urandom, rd, err, lat);
            chk("rnd_lat", 32'(lat), (op != 1) ? 32'd3 : 32'd5);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
